mem_arbiter: RTL and testbench

Two-master arbiter sharing the core's single memory port (32-bit, byte-masked, 1-cycle synchronous read latency) between the CPU (m0) and a second master (m1, e.g. loader/DMA). Each master uses the CPU-style pulse protocol (one-cycle `rstrb` or non-zero `wmask`) and gets back `rbusy`/`wbusy` stall flags. Uncontended accesses pass through in the strobe cycle with zero added latency. Contended accesses are buffered in a one-deep per-port slot and granted round-robin.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of both master ports and the shared memory port of mem_arbiter.
// slave: the arbiter's view. master: the view of the masters plus the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MW = DATA_W / 8;

  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [MW-1:0]     m0_wmask, m1_wmask;
  logic              m0_rstrb, m1_rstrb;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              m0_rbusy, m1_rbusy;
  logic              m0_wbusy, m1_wbusy;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MW-1:0]     mem_wmask;
  logic              mem_rstrb;
  logic [DATA_W-1:0] mem_rdata;

  logic              proto_err;

  modport slave (
    input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    output m0_rdata, m0_rbusy, m0_wbusy,
    output m1_rdata, m1_rbusy, m1_wbusy,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata,
    output proto_err
  );

  modport master (
    output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    input  m0_rdata, m0_rbusy, m0_wbusy,
    input  m1_rdata, m1_rbusy, m1_wbusy,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata,
    input  proto_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the single-cycle-latency memory port.
// Uncontended strobes pass straight through; a losing strobe parks in a
// one-deep per-port slot and competes again from the next cycle.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  bus
);
  localparam int MW = DATA_W / 8;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MW-1:0]     wmask;
  } req_t;

  req_t [1:0]             live, slot;
  req_t                   sel;
  logic [1:0]             slot_v, req_new, cand;
  logic                   gnt_any, gnt;
  logic                   last_grant, ret_v, ret_port, perr;
  logic [1:0][DATA_W-1:0] hold;

  // Live requests; a write mask wins over a simultaneous read strobe.
  // Gated by reset so nothing reaches memory while rstn is low.
  assign live[0]    = {(|bus.m0_wmask), bus.m0_addr, bus.m0_wdata, bus.m0_wmask};
  assign live[1]    = {(|bus.m1_wmask), bus.m1_addr, bus.m1_wdata, bus.m1_wmask};
  assign req_new[0] = rstn & (bus.m0_rstrb | (|bus.m0_wmask));
  assign req_new[1] = rstn & (bus.m1_rstrb | (|bus.m1_wmask));

  // Pick the winner: the sole candidate, else the port not granted last.
  always_comb begin
    cand    = slot_v | req_new;
    gnt_any = |cand;
    gnt     = (&cand) ? ~last_grant : ~cand[0];
    sel     = slot_v[gnt] ? slot[gnt] : live[gnt];
  end

  // Drive the memory port only during a grant, zeros otherwise.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;
    if (gnt_any) begin
      bus.mem_addr  = sel.addr;
      bus.mem_wdata = sel.wdata;
      bus.mem_wmask = sel.wr ? sel.wmask : '0;
      bus.mem_rstrb = ~sel.wr;
    end
  end

  // Per-port slot: clear on grant, capture a losing strobe when empty.
  // A strobe that arrives while the slot is full is dropped and flagged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_v <= '0;
      slot   <= '0;
      perr   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slot_v[i]) begin
          if (req_new[i]) perr <= 1'b1;
          if (gnt_any && gnt == 1'(i)) slot_v[i] <= 1'b0;
        end else if (req_new[i] && !(gnt_any && gnt == 1'(i))) begin
          slot_v[i] <= 1'b1;
          slot[i]   <= live[i];
        end
      end
    end
  end

  // Fairness pointer, read-return tracking and per-port read hold registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      ret_v      <= 1'b0;
      ret_port   <= 1'b0;
      hold       <= '0;
    end else begin
      if (gnt_any) last_grant <= gnt;
      ret_v    <= gnt_any & ~sel.wr;
      ret_port <= gnt;
      if (ret_v) hold[ret_port] <= bus.mem_rdata;
    end
  end

  // Return data goes straight through in the return cycle, else the hold copy.
  assign bus.m0_rdata  = (ret_v && !ret_port) ? bus.mem_rdata : hold[0];
  assign bus.m1_rdata  = (ret_v &&  ret_port) ? bus.mem_rdata : hold[1];
  assign bus.m0_rbusy  = slot_v[0] & ~slot[0].wr;
  assign bus.m0_wbusy  = slot_v[0] &  slot[0].wr;
  assign bus.m1_rbusy  = slot_v[1] & ~slot[1].wr;
  assign bus.m1_wbusy  = slot_v[1] &  slot[1].wr;
  assign bus.proto_err = perr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a few pinned words, a hash of the address elsewhere.
  logic [31:0] mem_pre [logic [31:0]];
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  // Memory stub: one-cycle read latency, random junk when no read is due.
  always @(posedge clk) bus.mem_rdata <= bus.mem_rstrb ? memval(bus.mem_addr) : $urandom;

  // ---------------- transaction model ----------------
  typedef struct {
    bit          v;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  mreq_t       pend[2];
  logic [31:0] hold_m[2];
  bit          ret_v_m;
  int          ret_p_m;
  logic [31:0] ret_a_m;
  int          last_m;
  bit          perr_m;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p].v = 1'b0;
      hold_m[p] = '0;
    end
    ret_v_m = 1'b0;
    last_m  = 1;
    perr_m  = 1'b0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    mreq_t       lv[2];
    mreq_t       gq;
    bit          c[2];
    bit          any;
    int          g;
    logic [31:0] exp_rd;
    lv[0] = '{v: bus.m0_rstrb | (|bus.m0_wmask), wr: |bus.m0_wmask,
              addr: bus.m0_addr, wdata: bus.m0_wdata, wmask: bus.m0_wmask};
    lv[1] = '{v: bus.m1_rstrb | (|bus.m1_wmask), wr: |bus.m1_wmask,
              addr: bus.m1_addr, wdata: bus.m1_wdata, wmask: bus.m1_wmask};
    if (!rstn) begin
      chk("rst mem_rstrb", bus.mem_rstrb, 0);
      chk("rst mem_wmask", bus.mem_wmask, 0);
      chk("rst mem_addr",  bus.mem_addr, 0);
      chk("rst mem_wdata", bus.mem_wdata, 0);
      chk("rst m0_rdata",  bus.m0_rdata, 0);
      chk("rst m1_rdata",  bus.m1_rdata, 0);
      chk("rst busy", {bus.m0_rbusy, bus.m0_wbusy, bus.m1_rbusy, bus.m1_wbusy}, 0);
      chk("rst proto_err", bus.proto_err, 0);
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) c[p] = pend[p].v || lv[p].v;
      any = c[0] || c[1];
      if (c[0] && c[1]) g = 1 - last_m;
      else              g = c[0] ? 0 : 1;
      gq = pend[g].v ? pend[g] : lv[g];

      chk("mem_rstrb", bus.mem_rstrb, (any && !gq.wr) ? 1 : 0);
      chk("mem_wmask", bus.mem_wmask, (any && gq.wr) ? gq.wmask : 4'h0);
      chk("mem_addr",  bus.mem_addr, any ? gq.addr : 32'h0);
      if (!any || gq.wr) chk("mem_wdata", bus.mem_wdata, any ? gq.wdata : 32'h0);

      for (int p = 0; p < 2; p++) begin
        exp_rd = (ret_v_m && ret_p_m == p) ? memval(ret_a_m) : hold_m[p];
        chk(p == 0 ? "m0_rdata" : "m1_rdata", p == 0 ? bus.m0_rdata : bus.m1_rdata, exp_rd);
      end
      chk("m0 busy", {bus.m0_rbusy, bus.m0_wbusy}, {pend[0].v && !pend[0].wr, pend[0].v && pend[0].wr});
      chk("m1 busy", {bus.m1_rbusy, bus.m1_wbusy}, {pend[1].v && !pend[1].wr, pend[1].v && pend[1].wr});
      chk("proto_err", bus.proto_err, perr_m);

      // advance to the next cycle
      if (ret_v_m) hold_m[ret_p_m] = memval(ret_a_m);
      ret_v_m = any && !gq.wr;
      ret_p_m = g;
      ret_a_m = gq.addr;
      for (int p = 0; p < 2; p++) begin
        if (pend[p].v) begin
          if (lv[p].v) perr_m = 1'b1;
          if (any && g == p) pend[p].v = 1'b0;
        end else if (lv[p].v && !(any && g == p)) begin
          pend[p] = lv[p];
        end
      end
      if (any) last_m = g;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.m0_rstrb = 0; bus.m0_wmask = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_rstrb = 0; bus.m1_wmask = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    if (p == 0) begin bus.m0_rstrb = 1; bus.m0_addr = a; end
    else        begin bus.m1_rstrb = 1; bus.m1_addr = a; end
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    if (p == 0) begin bus.m0_wmask = m; bus.m0_addr = a; bus.m0_wdata = d; end
    else        begin bus.m1_wmask = m; bus.m1_addr = a; bus.m1_wdata = d; end
  endtask

  // Move to just after the next rising edge with all strobes cleared.
  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic reset_pulse();
    step();
    rstn = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1;
  endtask

  initial begin
    bit pb0, pb1;
    int r;
    mem_pre[32'h100] = 32'hDEADBEEF;
    mem_pre[32'h200] = 32'hCAFEF00D;
    mem_pre[32'h204] = 32'h12345678;
    idle();
    rstn = 0;
    repeat (2) @(negedge clk);
    chk("reset m0_rdata", bus.m0_rdata, 32'h0);
    @(posedge clk); #1;
    rstn = 1;

    // uncontended read
    rd(0, 32'h100);
    @(negedge clk);
    chk("unc mem_rstrb", bus.mem_rstrb, 1);
    chk("unc mem_addr", bus.mem_addr, 32'h100);
    chk("unc m0_rbusy", bus.m0_rbusy, 0);
    step();
    @(negedge clk);
    chk("unc m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("unc m0_rbusy T+1", bus.m0_rbusy, 0);
    step(); step();
    @(negedge clk);
    chk("unc m0_rdata held", bus.m0_rdata, 32'hDEADBEEF);

    // contention right after reset: m0 wins
    reset_pulse();
    rd(0, 32'h10);
    wr(1, 32'h20, 32'h55AA55AA, 4'b1111);
    @(negedge clk);
    chk("cont T mem_addr", bus.mem_addr, 32'h10);
    chk("cont T mem_rstrb", bus.mem_rstrb, 1);
    step();
    @(negedge clk);
    chk("cont m1_wbusy T+1", bus.m1_wbusy, 1);
    chk("cont mem_wmask T+1", bus.mem_wmask, 4'b1111);
    chk("cont mem_addr T+1", bus.mem_addr, 32'h20);
    chk("cont mem_wdata T+1", bus.mem_wdata, 32'h55AA55AA);
    chk("cont m0_rdata T+1", bus.m0_rdata, memval(32'h10));
    step();
    @(negedge clk);
    chk("cont m1_wbusy T+2", bus.m1_wbusy, 0);

    // hold isolation
    step();
    rd(1, 32'h200);
    step();
    rd(0, 32'h204);
    @(negedge clk);
    chk("iso m1_rdata", bus.m1_rdata, 32'hCAFEF00D);
    step();
    @(negedge clk);
    chk("iso m0_rdata", bus.m0_rdata, 32'h12345678);
    chk("iso m1_rdata kept", bus.m1_rdata, 32'hCAFEF00D);

    // protocol violation: m1 strobes while its slot is full
    step();
    rd(1, 32'h300);
    step();
    rd(0, 32'h400);
    rd(1, 32'h304);
    @(negedge clk);
    chk("viol winner addr", bus.mem_addr, 32'h400);
    step();
    rd(1, 32'h308);
    @(negedge clk);
    chk("viol m1_rbusy", bus.m1_rbusy, 1);
    chk("viol slot addr", bus.mem_addr, 32'h304);
    chk("viol proto_err not yet", bus.proto_err, 0);
    step();
    @(negedge clk);
    chk("viol proto_err", bus.proto_err, 1);
    chk("viol m1_rdata", bus.m1_rdata, memval(32'h304));
    step();
    bus.m0_rstrb = 1;
    wr(0, 32'h40, 32'h11112222, 4'b0011);
    @(negedge clk);
    chk("rw mem_rstrb", bus.mem_rstrb, 0);
    chk("rw mem_wmask", bus.mem_wmask, 4'b0011);
    chk("proto_err sticky", bus.proto_err, 1);
    step();
    @(negedge clk);
    chk("rw no return", bus.m0_rdata, memval(32'h400));

    // round robin: both ports re-strobe whenever not busy
    reset_pulse();
    pb0 = 0; pb1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.m0_rbusy) rd(0, {$urandom_range(0, 255), 2'b00});
      if (!bus.m1_rbusy) rd(1, {$urandom_range(256, 511), 2'b00});
      @(negedge clk);
      chk("rr m0 wait", {pb0, bus.m0_rbusy}, {pb0, 1'b0} & {1'b1, 1'b0} | {pb0 & 1'b0, (bus.m0_rbusy & ~pb0)});
      chk("rr m1 wait", pb1 & bus.m1_rbusy, 0);
      pb0 = bus.m0_rbusy;
      pb1 = bus.m1_rbusy;
      step();
    end

    // randomized traffic, violations included
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, 9);
        if (r <= 3) rd(p, {$urandom_range(0, 63), 2'b00});
        else if (r <= 5) wr(p, {$urandom_range(0, 63), 2'b00}, $urandom, 4'($urandom_range(1, 15)));
        else if (r == 6) begin
          rd(p, {$urandom_range(0, 63), 2'b00});
          wr(p, {$urandom_range(0, 63), 2'b00}, $urandom, 4'($urandom_range(1, 15)));
        end
      end
      step();
    end

    // reset with m1 slot pending and m0 read in flight
    reset_pulse();
    rd(0, 32'h10);
    rd(1, 32'h20);
    step();
    #1 rstn = 0;
    @(negedge clk);
    chk("midrst m1_rbusy", bus.m1_rbusy, 0);
    chk("midrst m0_rdata", bus.m0_rdata, 0);
    chk("midrst mem_rstrb", bus.mem_rstrb, 0);
    chk("midrst proto_err", bus.proto_err, 0);
    @(posedge clk); #1;
    rstn = 1;
    rd(0, 32'h30);
    rd(1, 32'h34);
    @(negedge clk);
    chk("post-reset grant m0", bus.mem_addr, 32'h30);
    step();
    @(negedge clk);
    chk("post-reset m1 second", bus.mem_addr, 32'h34);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
